serial_adder: RTL and testbench

//  Bit-serial N-bit adder built around one full-adder bit cell (two half-adder stages, carry OR).

---
 rtl/serial_adder.sv | 69 ++++++
 tb/tb_serial_adder.sv | 128 ++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one full-adder cell fed LSB-first with a carry flop, start/busy/done handshake
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             co
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0, S_ADD = 2'd1, S_DONE = 2'd2;
  logic [1:0] state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_v;
  logic [WIDTH-2:0] sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic c_q, c_d, co_q, co_d;
  logic hs1_s, hs1_c, hs2_c, s, c_nxt, adding, last, accept;
  // full adder as two half-adder stages with the carries ORed
  assign hs1_s = a_q[0] ^ b_q[0];
  assign hs1_c = a_q[0] & b_q[0];
  assign s     = hs1_s ^ c_q;
  assign hs2_c = hs1_s & c_q;
  assign c_nxt = hs1_c | hs2_c;
  assign adding = state_q == S_ADD;
  assign last   = cnt_q == CW'(WIDTH - 1);
  assign accept = start && !adding;
  assign sum_v  = {s, sr_q};
  always_comb begin
    state_d = accept ? S_ADD : (adding ? (last ? S_DONE : S_ADD) : S_IDLE);
    a_d     = accept ? op1 : (adding ? a_q >> 1 : a_q);
    b_d     = accept ? op2 : (adding ? b_q >> 1 : b_q);
    c_d     = accept ? ci : (adding ? c_nxt : c_q);
    cnt_d   = accept ? '0 : (adding ? cnt_q + CW'(1) : cnt_q);
    sr_d    = adding ? sum_v[WIDTH-1:1] : sr_q;
    res_d   = (adding && last) ? sum_v : res_q;
    co_d    = (adding && last) ? c_nxt : co_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sr_q    <= '0;
      res_q   <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      res_q   <= res_d;
      co_q    <= co_d;
    end
  end
  assign busy = adding;
  assign done = state_q == S_DONE;
  assign res  = res_q;
  assign co   = co_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized and directed checks of serial_adder (WIDTH 8 against a cycle model, WIDTH 4 exhaustive)
module tb_serial_adder;
  logic clk = 1'b0, rst = 1'b1;
  logic start8 = 1'b0, ci8 = 1'b0, busy8, done8, co8;
  logic [7:0] op1_8 = '0, op2_8 = '0, res8;
  logic start4 = 1'b0, ci4 = 1'b0, busy4, done4, co4;
  logic [3:0] op1_4 = '0, op2_4 = '0, res4;
  int checks = 0, errors = 0;
  int m_left = 0;
  logic m_done = 1'b0, m_co = 1'b0;
  logic [7:0] m_res = '0;
  logic [8:0] m_pend = '0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .start(start8), .op1(op1_8), .op2(op2_8),
    .ci(ci8), .busy(busy8), .done(done8), .res(res8), .co(co8));
  serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .start(start4), .op1(op1_4), .op2(op2_4),
    .ci(ci4), .busy(busy4), .done(done4), .res(res4), .co(co4));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // reference: a pending sum becomes visible WIDTH edges after the accepting edge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_res  <= '0;
      m_co   <= 1'b0;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      m_done <= (m_left == 1);
      if (m_left == 1) {m_co, m_res} <= m_pend;
    end else begin
      m_done <= 1'b0;
      if (start8) begin
        m_pend <= {1'b0, op1_8} + {1'b0, op2_8} + {8'd0, ci8};
        m_left <= 8;
      end
    end
  end

  always @(negedge clk)
    if (!rst) chk("cycle8", {21'd0, busy8, done8, co8, res8}, {21'd0, m_left != 0, m_done, m_co, m_res});

  task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic c, input bit hold,
                     input logic [8:0] exp, input string nm);
    int n;
    start8 = 1'b1; op1_8 = a; op2_8 = b; ci8 = c;
    @(negedge clk);
    n = 0;
    while (!done8 && n < 20) begin
      n += int'(busy8);
      start8 = hold;
      op1_8 = 8'($urandom); op2_8 = 8'($urandom); ci8 = 1'($urandom);
      @(negedge clk);
    end
    start8 = 1'b0;
    chk({nm, "_lat"}, n, 8);
    chk({nm, "_done"}, {31'd0, done8}, 1);
    chk(nm, {23'd0, co8, res8}, {23'd0, exp});
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic rc;
    int n, dcount;
    #3;
    chk("reset_state", {busy8, done8, co8, res8, busy4, done4, co4, res4}, 0);
    #9 rst = 1'b0;
    @(negedge clk);
    go8(8'h3C, 8'h0F, 1'b0, 1'b0, 9'h04B, "t1");
    chk("model_pin", {23'd0, m_co, m_res}, 32'h04B);
    @(negedge clk);
    go8(8'hFF, 8'h01, 1'b0, 1'b0, 9'h100, "t2a");
    go8(8'hFF, 8'hFF, 1'b1, 1'b0, 9'h1FF, "t2b");
    @(negedge clk);
    go8(8'hA5, 8'h5A, 1'b1, 1'b1, 9'h100, "t3_hold");
    @(negedge clk);
    @(negedge clk);
    go8(8'h10, 8'h20, 1'b0, 1'b0, 9'h030, "t4_first");
    go8(8'h01, 8'h01, 1'b0, 1'b0, 9'h002, "t4_b2b");
    @(negedge clk);
    start8 = 1'b1; op1_8 = 8'h77; op2_8 = 8'h99; ci8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("t5_async_rst", {28'd0, busy8, done8, co8, |res8}, 0);
    #1 rst = 1'b0;
    dcount = 0;
    repeat (12) begin
      @(negedge clk);
      dcount += int'(done8);
    end
    chk("t5_no_done", dcount, 0);
    go8(8'h12, 8'h34, 1'b1, 1'b0, 9'h047, "t5_next");
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      go8(ra, rb, rc, 1'b0, {1'b0, ra} + {1'b0, rb} + {8'd0, rc}, "rand8");
    end
    @(negedge clk);
    for (int i = 0; i < 512; i++) begin
      start4 = 1'b1; op1_4 = 4'(i); op2_4 = 4'(i >> 4); ci4 = 1'(i >> 8);
      @(negedge clk);
      start4 = 1'b0;
      n = 0;
      while (!done4 && n < 12) begin
        n += int'(busy4);
        op1_4 = 4'($urandom); op2_4 = 4'($urandom);
        @(negedge clk);
      end
      chk("exh4_lat", n, 4);
      chk("exh4_sum", {27'd0, co4, res4}, (i & 15) + ((i >> 4) & 15) + (i >> 8));
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
